// File: rtl/dpram_stream_fifo_pkg.sv
// ---------------------------------------------------------------------------
// dpram_stream_fifo_pkg
//
// Shared helpers for the dual-port-RAM backed stream FIFO and its output
// buffer.
//   countWidth(aw)        width of the occupancy counter (RAM words plus the
//                         read pipeline and output buffer need two extra bits)
//   obufDepth(nDelay)     entries in the output buffer: one per RAM pipeline
//                         stage plus the word currently presented downstream
//   wrapInc(ptr, depth)   pointer increment with explicit wrap, so depths
//                         that are not a power of two work
// ---------------------------------------------------------------------------
package dpram_stream_fifo_pkg;

    localparam int unsigned DEFAULT_DW      = 32;
    localparam int unsigned DEFAULT_AW      = 8;
    localparam int unsigned DEFAULT_DEPTH   = 256;
    localparam int unsigned DEFAULT_N_DELAY = 1;

    function automatic int unsigned countWidth(input int unsigned aw);
        return aw + 2;
    endfunction

    function automatic int unsigned obufDepth(input int unsigned nDelay);
        return nDelay + 1;
    endfunction

    function automatic int unsigned wrapInc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dpram_stream_fifo_obuf.sv
// ---------------------------------------------------------------------------
// dpram_stream_obuf
//
// Small circular buffer that catches words coming out of the RAM read
// pipeline and presents them to the downstream consumer.
//   clk, rstn    clock, asynchronous active-low reset
//   push_i       store data_i this cycle
//   data_i       word to store (RAM read data)
//   pop_i        consumer takes the head word this cycle
//   valid_o      buffer holds at least one word
//   data_o       head word, zero when empty; depends only on registers
//   cnt_o        number of words held
// The caller guarantees push_i never arrives while the buffer is full.
// ---------------------------------------------------------------------------
module dpram_stream_obuf
    import dpram_stream_fifo_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] cnt_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [IW-1:0] wrIdx_q;
    logic [IW-1:0] rdIdx_q;
    logic [CW-1:0] cnt_q;

    // Storage, indices and fill level; push and pop in the same cycle keep
    // the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wrIdx_q <= '0;
            rdIdx_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrIdx_q] <= data_i;
                wrIdx_q        <= IW'(wrapInc(32'(wrIdx_q), DEPTH));
            end
            if (pop_i) begin
                rdIdx_q <= IW'(wrapInc(32'(rdIdx_q), DEPTH));
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rdIdx_q] : '0;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/dpram_stream_fifo.sv
// ---------------------------------------------------------------------------
// dpram_stream_fifo
//
// Valid/ready stream FIFO whose storage is an external dual-port RAM with a
// fixed read latency of N_DELAY cycles.
//   clk, rstn                    clock, asynchronous active-low reset
//   s_valid, s_ready, s_data     upstream stream (write side)
//   m_valid, m_ready, m_data     downstream stream (read side)
//   count                        words held: RAM + reads in flight + output buffer
//   ram_ena, ram_wea,
//   ram_addra, ram_dia           RAM port A (write)
//   ram_enb, ram_addrb, ram_dob  RAM port B (read), data N_DELAY cycles after address
//
// A word written in one cycle becomes readable from the next, so the two
// RAM ports never touch the same address in the same cycle. Reads are
// credit limited so the output buffer can always absorb every word that is
// already in the RAM pipeline.
// ---------------------------------------------------------------------------
module dpram_stream_fifo
    import dpram_stream_fifo_pkg::*;
#(
    parameter int unsigned DW      = DEFAULT_DW,
    parameter int unsigned AW      = DEFAULT_AW,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned N_DELAY = DEFAULT_N_DELAY
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DW-1:0]            m_data,
    output logic [countWidth(AW)-1:0] count,
    output logic                     ram_ena,
    output logic                     ram_wea,
    output logic [AW-1:0]            ram_addra,
    output logic [DW-1:0]            ram_dia,
    output logic                     ram_enb,
    output logic [AW-1:0]            ram_addrb,
    input  logic [DW-1:0]            ram_dob
);

    localparam int unsigned CW         = countWidth(AW);
    localparam int unsigned OBUF_DEPTH = obufDepth(N_DELAY);
    localparam int unsigned OCW        = $clog2(OBUF_DEPTH + 1);

    logic [AW-1:0]      wrPtr_q, wrPtr_d;
    logic [AW-1:0]      rdPtr_q, rdPtr_d;
    logic [AW-1:0]      addrB_q;
    logic [CW-1:0]      memUsed_q, memUsed_d;
    logic [CW-1:0]      count_q, count_d;
    logic               sReady_q, sReady_d;
    logic [N_DELAY-1:0] inflight_q, inflight_d;

    logic [CW-1:0]      inflightCnt;
    logic [CW-1:0]      occupancy;
    logic [OCW-1:0]     obufCnt;
    logic               obufValid;
    logic [DW-1:0]      obufData;
    logic               wrFire;
    logic               rdFire;
    logic               popFire;
    logic               obufPush;

    assign wrFire   = s_valid & sReady_q;
    assign popFire  = obufValid & m_ready;
    assign obufPush = inflight_q[N_DELAY-1];

    // Number of read tokens still travelling through the RAM pipeline.
    always_comb begin
        inflightCnt = '0;
        for (int i = 0; i < int'(N_DELAY); i++) begin
            inflightCnt = inflightCnt + CW'(inflight_q[i]);
        end
    end

    // Output-buffer slots already claimed. A pop this cycle frees its slot
    // before any newly issued read can land, which is what allows one word
    // per cycle in steady state without ever overflowing the buffer.
    assign occupancy = CW'(obufCnt) + inflightCnt - CW'(popFire);
    assign rdFire    = (memUsed_q != '0) && (occupancy < CW'(OBUF_DEPTH));

    // Next-state logic for pointers, RAM fill level, ready and total count.
    // The total only moves on an accepted write or a downstream pop, so it
    // is tracked directly rather than summed from its three parts.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        inflight_d = '0;
        if (wrFire) begin
            wrPtr_d = AW'(wrapInc(32'(wrPtr_q), DEPTH));
        end
        if (rdFire) begin
            rdPtr_d = AW'(wrapInc(32'(rdPtr_q), DEPTH));
        end
        memUsed_d = memUsed_q + CW'(wrFire) - CW'(rdFire);
        sReady_d  = (memUsed_d < CW'(DEPTH));
        count_d   = count_q + CW'(wrFire) - CW'(popFire);
        inflight_d[0] = rdFire;
        for (int i = 1; i < int'(N_DELAY); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    // State registers. The token shift register advances every cycle in
    // lock step with the RAM read pipeline, whose port B is always enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            addrB_q    <= '0;
            memUsed_q  <= '0;
            count_q    <= '0;
            sReady_q   <= 1'b0;
            inflight_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            addrB_q    <= ram_addrb;
            memUsed_q  <= memUsed_d;
            count_q    <= count_d;
            sReady_q   <= sReady_d;
            inflight_q <= inflight_d;
        end
    end

    dpram_stream_obuf #(
        .DW    (DW),
        .DEPTH (OBUF_DEPTH),
        .CW    (OCW)
    ) uObuf (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (obufPush),
        .data_i  (ram_dob),
        .pop_i   (popFire),
        .valid_o (obufValid),
        .data_o  (obufData),
        .cnt_o   (obufCnt)
    );

    // Read address holds its last value when no read is issued.
    assign ram_addrb = rdFire ? rdPtr_q : addrB_q;
    assign ram_enb   = rstn;
    assign ram_ena   = wrFire;
    assign ram_wea   = wrFire;
    assign ram_addra = wrPtr_q;
    assign ram_dia   = s_data;

    assign s_ready = sReady_q;
    assign m_valid = obufValid;
    assign m_data  = obufData;
    assign count   = count_q;

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_dpram_stream_fifo
//
// Self-checking bench for dpram_stream_fifo with a behavioural dual-port RAM
// of matching latency. Uses a non-power-of-two depth and a multi-cycle read
// latency. A negedge monitor keeps a scoreboard queue of accepted words and
// a model of the total word count.
// ---------------------------------------------------------------------------
module tb_dpram_stream_fifo;

    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int DEPTH      = 26;
    localparam int N_DELAY    = 3;
    localparam int CW         = AW + 2;
    localparam int FULL_COUNT = DEPTH + N_DELAY + 1;

    logic          clk;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;

    int compareCount  = 0;
    int mismatchCount = 0;
    int modelCount    = 0;
    logic [DW-1:0] expQ [$];

    dpram_stream_fifo #(
        .DW      (DW),
        .AW      (AW),
        .DEPTH   (DEPTH),
        .N_DELAY (N_DELAY)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: synchronous write, read data N_DELAY cycles later.
    logic [DW-1:0] ramMem   [2**AW];
    logic [DW-1:0] readPipe [N_DELAY];

    always @(posedge clk) begin
        if (ram_ena && ram_wea) begin
            ramMem[ram_addra] <= ram_dia;
        end
        if (ram_enb) begin
            readPipe[0] <= ramMem[ram_addrb];
            for (int i = 1; i < N_DELAY; i++) begin
                readPipe[i] <= readPipe[i-1];
            end
        end
    end
    assign ram_dob = readPipe[N_DELAY-1];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic ready);
        s_valid = valid;
        s_data  = data;
        m_ready = ready;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: checks the count model every cycle, compares each
    // popped word against the oldest accepted word, then records this
    // cycle's transfers. Reset wipes the model.
    always @(negedge clk) begin
        int wr;
        int rd;
        if (!rstn) begin
            expQ.delete();
            modelCount = 0;
        end else begin
            wr = (s_valid && s_ready) ? 1 : 0;
            rd = (m_valid && m_ready) ? 1 : 0;
            checkOutput("count", 64'(count), 64'(modelCount));
            if (rd == 1) begin
                if (expQ.size() == 0) begin
                    checkOutput("pop_with_empty_model", 64'(1), 64'(0));
                end else begin
                    checkOutput("m_data", 64'(m_data), 64'(expQ.pop_front()));
                end
            end
            if (wr == 1) begin
                expQ.push_back(s_data);
            end
            modelCount = modelCount + wr - rd;
        end
    end

    // Continuous stream with both sides always ready; counts gaps in the
    // output once the first word has appeared.
    task automatic runStream(input int n, input logic [DW-1:0] base);
        int sent    = 0;
        int seen    = 0;
        int bubbles = 0;
        int cycles  = 0;
        applyStimulus(1'b1, base, 1'b1);
        while (seen < n && cycles < n + 100) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            if (m_valid) seen++;
            else if (seen > 0) bubbles++;
            stepCycle();
            cycles++;
            applyStimulus(sent < n, base + DW'(sent), 1'b1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream_words", 64'(seen), 64'(n));
        checkOutput("stream_bubbles", 64'(bubbles), 64'(0));
    endtask

    // Fill with the consumer stalled; s_valid stays high on the same word
    // until it is accepted.
    task automatic fillUp(input logic [DW-1:0] base, output int accepted);
        accepted = 0;
        applyStimulus(1'b1, base, 1'b0);
        for (int c = 0; c < DEPTH + 20; c++) begin
            @(negedge clk);
            if (s_valid && s_ready) accepted++;
            stepCycle();
            applyStimulus(1'b1, base + DW'(accepted), 1'b0);
        end
    endtask

    task automatic waitDrained(input string tag);
        int cycles = 0;
        while (count != '0 && cycles < 500) begin
            stepCycle();
            cycles++;
        end
        checkOutput(tag, 64'(count), 64'(0));
    endtask

    initial begin
        int lat;
        int accepted;
        int sent;
        int cycles;
        int lateValid;

        rstn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_ready", 64'(s_ready), 64'(0));
        checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
        checkOutput("rst_m_data", 64'(m_data), 64'(0));
        checkOutput("rst_count", 64'(count), 64'(0));
        checkOutput("rst_ram_enb", 64'(ram_enb), 64'(0));
        checkOutput("rst_ram_addrb", 64'(ram_addrb), 64'(0));

        rstn = 1'b1;
        stepCycle();
        checkOutput("idle_s_ready", 64'(s_ready), 64'(1));
        checkOutput("idle_m_valid", 64'(m_valid), 64'(0));
        checkOutput("idle_count", 64'(count), 64'(0));
        checkOutput("idle_ram_enb", 64'(ram_enb), 64'(1));

        $display("[TB] single word latency");
        applyStimulus(1'b1, 32'hA5A5_0001, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        lat = 1;
        while (!m_valid && lat < 20) begin
            stepCycle();
            lat++;
        end
        checkOutput("single_latency", 64'(lat), 64'(2 + N_DELAY));
        checkOutput("single_data", 64'(m_data), 64'(32'hA5A5_0001));
        stepCycle();
        checkOutput("single_m_valid_after_pop", 64'(m_valid), 64'(0));
        checkOutput("single_count_after_pop", 64'(count), 64'(0));

        $display("[TB] continuous stream");
        runStream(1000, 32'h0000_1000);
        waitDrained("stream_drain");

        $display("[TB] fill and drain");
        fillUp(32'h1000_0000, accepted);
        checkOutput("fill_accepted", 64'(accepted), 64'(FULL_COUNT));
        checkOutput("fill_s_ready", 64'(s_ready), 64'(0));
        checkOutput("fill_count", 64'(count), 64'(FULL_COUNT));
        checkOutput("fill_m_valid", 64'(m_valid), 64'(1));
        checkOutput("fill_head", 64'(m_data), 64'(32'h1000_0000));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain_ready_still_low", 64'(s_ready), 64'(0));
        stepCycle();
        checkOutput("drain_ready_reasserts", 64'(s_ready), 64'(1));
        waitDrained("fill_drain");
        checkOutput("fill_model_empty", 64'(expQ.size()), 64'(0));

        $display("[TB] random traffic");
        sent   = 0;
        cycles = 0;
        applyStimulus(1'($urandom_range(0, 1)), 32'h4000_0000, 1'($urandom_range(0, 1)));
        while ((sent < 10000 || count != '0) && cycles < 60000) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            stepCycle();
            cycles++;
            applyStimulus((sent < 10000) && ($urandom_range(0, 1) == 1),
                          32'h4000_0000 + DW'(sent), 1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("random_sent", 64'(sent), 64'(10000));
        checkOutput("random_count_zero", 64'(count), 64'(0));

        $display("[TB] reset while holding data");
        fillUp(32'h2000_0000, accepted);
        checkOutput("prereset_count", 64'(count), 64'(FULL_COUNT));
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midrst_s_ready", 64'(s_ready), 64'(0));
        checkOutput("midrst_m_valid", 64'(m_valid), 64'(0));
        checkOutput("midrst_m_data", 64'(m_data), 64'(0));
        checkOutput("midrst_count", 64'(count), 64'(0));
        checkOutput("midrst_ram_ena", 64'(ram_ena), 64'(0));
        checkOutput("midrst_ram_enb", 64'(ram_enb), 64'(0));
        checkOutput("midrst_ram_addra", 64'(ram_addra), 64'(0));
        checkOutput("midrst_ram_addrb", 64'(ram_addrb), 64'(0));
        applyStimulus(1'b0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        lateValid = 0;
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            if (m_valid) lateValid++;
        end
        checkOutput("postrst_no_valid", 64'(lateValid), 64'(0));
        runStream(20, 32'hC0DE_0000);
        waitDrained("postrst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
